mem_store_buffer: RTL and testbench
===================================

# mem_store_buffer

Posted-store write buffer between the MEM stage and the data cache. Accepts MEM's memory requests; stores retire into a FIFO in the cycle they are presented and drain to the cache in the background. Loads go to the cache only after any same-word stores are resolved. Cuts MEM store stalls to zero while the buffer has space.

## Interface
- DEPTH, 4: store entries (power of two, ≥2).
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low.
- MemRead_IN, MemWrite_IN, MemFlush_IN  in  1 each  request from MEM (at most one high).
- Addr_IN  in  32  byte address; stores may be unaligned (SWL), loads are word-aligned.
- WData_IN  in  32  store data.
- WSize_IN  in  2  0=word, 1=byte, 2=half, 3=three bytes.
- RData_OUT  out  32  load data to MEM.
- Valid_OUT  out  1  request complete this cycle; MEM stalls while it is low and a request is up.
- DC_Read, DC_Write, DC_Flush  out  1 each  cache request.
- DC_Addr  out  32; DC_WData  out  32; DC_WSize  out  2.
- DC_RData  in  32; DC_Valid  in  1  cache done (one-cycle pulse).

## Operation
- FIFO of {addr, data, size}; head/tail pointers with an extra wrap bit; full = DEPTH entries.
- Store: if not full → enqueue at posedge, Valid_OUT=1 combinationally that cycle. If full → Valid_OUT=0 and retry next cycle.
- Load conflict: any valid entry with addr[31:2]==Addr_IN[31:2].
- Load, no conflict: issue DC_Read (state LOAD); Valid_OUT=1 with RData_OUT=DC_RData in the DC_Valid cycle.
- Load, conflict: Valid_OUT=0; drain continues until no entry matches, then the load is issued.
- Flush: drain to empty, issue DC_Flush (state FLUSH), Valid_OUT=1 on DC_Valid.
- FSM: IDLE, LOAD, DRAIN, FLUSH.
  - IDLE→LOAD: non-conflicting load pending.
  - IDLE→DRAIN: otherwise, if FIFO is non-empty.
  - IDLE→FLUSH: flush pending and FIFO empty.
  - LOAD/DRAIN/FLUSH→IDLE: on DC_Valid. In DRAIN, the head pops on that edge.
- Priority in IDLE: non-conflicting load > drain > flush. Loads are never blocked by unrelated stores.
- Enqueue and pop in the same cycle are both honoured; occupancy is unchanged, including when full.
- DC_* outputs are registered and held stable until DC_Valid. The entry is sent as enqueued; address/size are not realigned.

## Timing
- Reset: FIFO empty, state IDLE, RData_OUT=0, all DC_* outputs 0.
- Valid_OUT is combinational and low during reset.
- Reset mid-transaction abandons the outstanding cache request and discards buffered stores.
- Store accept: 0-cycle stall. Store drain: ≥2 cycles (request register + DC_Valid).
- Load hit path: request at edge N+1 after presentation; data in the DC_Valid cycle.
- A DC_Valid arriving in IDLE is ignored.
- A store presented while a load or flush is in flight is still enqueued if there is space.

## Configuration
- MEM_STORE_FWD_EN defined: a conflicting load is answered from the buffer instead of waiting, when the youngest matching entry has WSize=0 and addr[1:0]=0.
  - Valid_OUT=1 the same cycle; RData_OUT = that entry's data; no cache access.
  - Any other conflict drains as in the undefined case.
- Undefined: every conflict drains.

## Structure
- Shared package holds:
  - size encodings: WSIZE_WORD=0, WSIZE_BYTE=1, WSIZE_HALF=2, WSIZE_3B=3;
  - FSM state constants;
  - the store-entry record typedef.
- One sub-module: store_fifo.
  - Holds storage, pointers, full/empty.
  - Provides a parallel compare port giving a per-entry match vector and youngest-match index/data.

## Test plan
- Reset, then 4 word stores to 0x100, 0x104, 0x108, 0x10C with DC_Valid withheld:
  - each store sees Valid_OUT=1 in the cycle it is presented;
  - a 5th store sees Valid_OUT=0 until the first DC_Valid.
- Store 0xDEADBEEF to 0x200, then load 0x300 (DC_Valid=1 with DC_RData=0x12345678, 3 cycles after DC_Read):
  - the load issues before the store drains;
  - RData_OUT=0x12345678.
- Store 0xCAFEF00D to 0x400, then load 0x400:
  - with the macro defined: Valid_OUT=1 the same cycle, RData_OUT=0xCAFEF00D, no DC_Read;
  - undefined: DC_Write completes before DC_Read.
- Byte store (size 1) to 0x401, then load 0x400: the load waits for the drain under both configurations.
- Flush with 3 entries queued: exactly 3 DC_Write, then 1 DC_Flush, then Valid_OUT=1.
- Assert RESET low while DRAIN is waiting on DC_Valid: FIFO is empty, DC_Write=0, state IDLE next cycle.

Source files
------------

// File: rtl/mem_store_buffer_pkg.sv
// Shared definitions for the MEM-stage posted-store buffer.
//   - store size encodings (as carried on WSize_IN / DC_WSize)
//   - cache-side FSM state type
//   - buffered store record and a same-word compare helper
package mem_store_buffer_pkg;

  localparam logic [1:0] WSIZE_WORD = 2'd0;
  localparam logic [1:0] WSIZE_BYTE = 2'd1;
  localparam logic [1:0] WSIZE_HALF = 2'd2;
  localparam logic [1:0] WSIZE_3B   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } sb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } sb_entry_t;

  // Two byte addresses fall in the same 32-bit word.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/mem_store_buffer_fifo.sv
// store_fifo: circular store queue for mem_store_buffer.
// Ports:
//   CLK, RESET          clock, asynchronous active-low reset (empties queue)
//   i_push, i_entry     enqueue a store record at the tail
//   i_pop               drop the head record
//   o_head              record at the head
//   o_full, o_empty     occupancy flags
//   i_cmp_addr          byte address compared against every valid entry
//   o_match_vec         per-slot same-word match (valid slots only)
//   o_match_any         at least one slot matches
//   o_young_idx         slot of the most recently enqueued matching entry
//   o_young_entry       record held in that slot
module store_fifo
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       i_push,
  input  sb_entry_t                  i_entry,
  input  logic                       i_pop,
  output sb_entry_t                  o_head,
  output logic                       o_full,
  output logic                       o_empty,
  input  logic [31:0]                i_cmp_addr,
  output logic [DEPTH-1:0]           o_match_vec,
  output logic                       o_match_any,
  output logic [$clog2(DEPTH)-1:0]   o_young_idx,
  output sb_entry_t                  o_young_entry
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  sb_entry_t   r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] w_count;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; validity comes from the pointers alone.
  // A push while full is only issued together with a pop, so the slot
  // written is the head being retired on the same edge.
  always_ff @(posedge CLK) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
  end

  // Walk from oldest to newest; the last hit seen is the youngest match.
  always_comb begin
    logic [AW-1:0] v_slot;
    o_match_vec = '0;
    o_match_any = 1'b0;
    o_young_idx = '0;
    v_slot      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v_slot = r_rd_ptr[AW-1:0] + i[AW-1:0];
      if (i < 32'(w_count) && same_word(r_mem[v_slot].addr, i_cmp_addr)) begin
        o_match_vec[v_slot] = 1'b1;
        o_match_any         = 1'b1;
        o_young_idx         = v_slot;
      end
    end
  end

  assign o_young_entry = r_mem[o_young_idx];

endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: posted-store write buffer between MEM and the data cache.
// Stores retire into a queue in the cycle they are presented and drain to the
// cache in the background; loads wait only for same-word stores.
// Optional feature macro: MEM_STORE_FWD_EN -- answer a conflicting load from
// the buffer when the youngest matching entry is an aligned full word.
// Ports:
//   CLK, RESET                           clock, async active-low reset
//   MemRead_IN/MemWrite_IN/MemFlush_IN   MEM request (one-hot or idle)
//   Addr_IN, WData_IN, WSize_IN          request address, store data, size
//   RData_OUT, Valid_OUT                 load data, request complete (comb)
//   DC_Read/DC_Write/DC_Flush            registered cache request strobes
//   DC_Addr, DC_WData, DC_WSize          registered cache request payload
//   DC_RData, DC_Valid                   cache read data, completion pulse
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_IN,
  input  logic        MemWrite_IN,
  input  logic        MemFlush_IN,
  input  logic [31:0] Addr_IN,
  input  logic [31:0] WData_IN,
  input  logic [1:0]  WSize_IN,
  output logic [31:0] RData_OUT,
  output logic        Valid_OUT,
  output logic        DC_Read,
  output logic        DC_Write,
  output logic        DC_Flush,
  output logic [31:0] DC_Addr,
  output logic [31:0] DC_WData,
  output logic [1:0]  DC_WSize,
  input  logic [31:0] DC_RData,
  input  logic        DC_Valid
);

  sb_state_e r_state, w_state_nxt;

  logic        r_dc_read,  w_dc_read_nxt;
  logic        r_dc_write, w_dc_write_nxt;
  logic        r_dc_flush, w_dc_flush_nxt;
  logic [31:0] r_dc_addr,  w_dc_addr_nxt;
  logic [31:0] r_dc_wdata, w_dc_wdata_nxt;
  logic [1:0]  r_dc_wsize, w_dc_wsize_nxt;
  logic [31:0] r_rdata;

  sb_entry_t                w_entry;
  sb_entry_t                w_head;
  sb_entry_t                w_young;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic [DEPTH-1:0]         w_match_vec;
  logic                     w_match_any;
  logic [$clog2(DEPTH)-1:0] w_young_idx;
  logic                     w_fwd_hit;
  logic                     w_load_go;
  logic                     w_load_done;
  logic                     w_unused_cmp;

  assign w_entry = '{addr: Addr_IN, data: WData_IN, size: WSize_IN};

  // Head retires on the DC_Valid edge of a drain; a store arriving in that
  // same cycle can take the freed slot even when the queue is full.
  assign w_pop  = (r_state == ST_DRAIN) && DC_Valid;
  assign w_push = MemWrite_IN && (!w_full || w_pop);

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK           (CLK),
    .RESET         (RESET),
    .i_push        (w_push),
    .i_entry       (w_entry),
    .i_pop         (w_pop),
    .o_head        (w_head),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .i_cmp_addr    (Addr_IN),
    .o_match_vec   (w_match_vec),
    .o_match_any   (w_match_any),
    .o_young_idx   (w_young_idx),
    .o_young_entry (w_young)
  );

  assign w_unused_cmp = ^{w_match_vec, w_young_idx, w_young};

`ifdef MEM_STORE_FWD_EN
  // Only an aligned full-word store fully covers the loaded word.
  assign w_fwd_hit = MemRead_IN && w_match_any && (r_state != ST_LOAD) &&
                     (w_young.size == WSIZE_WORD) && (w_young.addr[1:0] == 2'b00);
`else
  assign w_fwd_hit = 1'b0;
`endif

  assign w_load_go   = MemRead_IN && !w_match_any;
  assign w_load_done = (r_state == ST_LOAD) && DC_Valid;

  assign Valid_OUT = RESET &&
                     ((MemWrite_IN && (!w_full || w_pop)) ||
                      (MemRead_IN  && (w_fwd_hit || w_load_done)) ||
                      (MemFlush_IN && (r_state == ST_FLUSH) && DC_Valid));

  assign RData_OUT = w_fwd_hit   ? w_young.data :
                     w_load_done ? DC_RData     : r_rdata;

  always_comb begin
    w_state_nxt    = r_state;
    w_dc_read_nxt  = r_dc_read;
    w_dc_write_nxt = r_dc_write;
    w_dc_flush_nxt = r_dc_flush;
    w_dc_addr_nxt  = r_dc_addr;
    w_dc_wdata_nxt = r_dc_wdata;
    w_dc_wsize_nxt = r_dc_wsize;
    case (r_state)
      ST_IDLE: begin
        if (w_load_go) begin
          w_state_nxt    = ST_LOAD;
          w_dc_read_nxt  = 1'b1;
          w_dc_addr_nxt  = Addr_IN;
          w_dc_wdata_nxt = '0;
          w_dc_wsize_nxt = WSIZE_WORD;
        end else if (!w_empty) begin
          w_state_nxt    = ST_DRAIN;
          w_dc_write_nxt = 1'b1;
          w_dc_addr_nxt  = w_head.addr;
          w_dc_wdata_nxt = w_head.data;
          w_dc_wsize_nxt = w_head.size;
        end else if (MemFlush_IN) begin
          w_state_nxt    = ST_FLUSH;
          w_dc_flush_nxt = 1'b1;
          w_dc_addr_nxt  = '0;
          w_dc_wdata_nxt = '0;
          w_dc_wsize_nxt = WSIZE_WORD;
        end
      end
      ST_LOAD, ST_DRAIN, ST_FLUSH: begin
        if (DC_Valid) begin
          w_state_nxt    = ST_IDLE;
          w_dc_read_nxt  = 1'b0;
          w_dc_write_nxt = 1'b0;
          w_dc_flush_nxt = 1'b0;
          w_dc_addr_nxt  = '0;
          w_dc_wdata_nxt = '0;
          w_dc_wsize_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_dc_read  <= 1'b0;
      r_dc_write <= 1'b0;
      r_dc_flush <= 1'b0;
      r_dc_addr  <= '0;
      r_dc_wdata <= '0;
      r_dc_wsize <= '0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dc_read  <= w_dc_read_nxt;
      r_dc_write <= w_dc_write_nxt;
      r_dc_flush <= w_dc_flush_nxt;
      r_dc_addr  <= w_dc_addr_nxt;
      r_dc_wdata <= w_dc_wdata_nxt;
      r_dc_wsize <= w_dc_wsize_nxt;
      if (MemRead_IN && (w_fwd_hit || w_load_done)) r_rdata <= RData_OUT;
    end
  end

  assign DC_Read  = r_dc_read;
  assign DC_Write = r_dc_write;
  assign DC_Flush = r_dc_flush;
  assign DC_Addr  = r_dc_addr;
  assign DC_WData = r_dc_wdata;
  assign DC_WSize = r_dc_wsize;

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemRead_IN, MemWrite_IN, MemFlush_IN;
  logic [31:0] Addr_IN, WData_IN;
  logic [1:0]  WSize_IN;
  logic [31:0] RData_OUT;
  logic        Valid_OUT;
  logic        DC_Read, DC_Write, DC_Flush;
  logic [31:0] DC_Addr, DC_WData;
  logic [1:0]  DC_WSize;
  logic [31:0] DC_RData;
  logic        DC_Valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  mem_store_buffer #(.DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN), .MemFlush_IN(MemFlush_IN),
    .Addr_IN(Addr_IN), .WData_IN(WData_IN), .WSize_IN(WSize_IN),
    .RData_OUT(RData_OUT), .Valid_OUT(Valid_OUT),
    .DC_Read(DC_Read), .DC_Write(DC_Write), .DC_Flush(DC_Flush),
    .DC_Addr(DC_Addr), .DC_WData(DC_WData), .DC_WSize(DC_WSize),
    .DC_RData(DC_RData), .DC_Valid(DC_Valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    MemRead_IN = 1'b0; MemWrite_IN = 1'b0; MemFlush_IN = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    MemRead_IN = 1'b0; MemFlush_IN = 1'b0; MemWrite_IN = 1'b1;
    Addr_IN = a; WData_IN = d; WSize_IN = s;
  endtask

  task automatic load(input logic [31:0] a);
    MemWrite_IN = 1'b0; MemFlush_IN = 1'b0; MemRead_IN = 1'b1;
    Addr_IN = a; WData_IN = '0; WSize_IN = 2'd0;
  endtask

  task automatic pulse(input logic [31:0] rd);
    DC_Valid = 1'b1; DC_RData = rd;
    step();
    DC_Valid = 1'b0;
  endtask

  // Bounded wait for a cache write request to appear.
  task automatic wait_write(input string tag);
    bit seen;
    seen = 1'b0;
    for (int unsigned k = 0; k < 50 && !seen; k++) begin
      if (DC_Write) seen = 1'b1;
      else step();
    end
    chkb(tag, seen, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    bit done;
    RESET = 1'b0; idle(); Addr_IN = '0; WData_IN = '0; WSize_IN = '0;
    DC_RData = '0; DC_Valid = 1'b0;

    // Reset state
    MemWrite_IN = 1'b1;
    #2;
    chkb("rst_valid_low", Valid_OUT, 1'b0);
    step(); step();
    chkb("rst_dc_read", DC_Read, 1'b0);
    chkb("rst_dc_write", DC_Write, 1'b0);
    chkb("rst_dc_flush", DC_Flush, 1'b0);
    chk ("rst_dc_addr", DC_Addr, 32'h0);
    chk ("rst_rdata", RData_OUT, 32'h0);
    idle();
    RESET = 1'b1;
    step();

    // Fill the buffer with DC_Valid withheld
    for (int i = 0; i < 4; i++) begin
      store(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 2'd0);
      #1 chkb("fill_valid", Valid_OUT, 1'b1);
      step();
    end
    store(32'h110, 32'hA000_0004, 2'd0);
    #1 chkb("full_stall0", Valid_OUT, 1'b0);
    chkb("full_drain_up", DC_Write, 1'b1);
    chk ("full_drain_addr", DC_Addr, 32'h100);
    step();
    chkb("full_stall1", Valid_OUT, 1'b0);
    DC_Valid = 1'b1;
    #1 chkb("full_pop_accept", Valid_OUT, 1'b1);
    step();
    DC_Valid = 1'b0; idle();
    chkb("pop_to_idle", DC_Write, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_write("drain_wait");
      chk("drain_addr", DC_Addr, 32'h104 + 32'(4*i));
      chk("drain_data", DC_WData, 32'hA000_0001 + 32'(i));
      pulse(32'h0);
    end
    step(); step();
    chkb("drain_empty", DC_Write, 1'b0);

    // Unrelated load bypasses a pending store
    store(32'h200, 32'hDEAD_BEEF, 2'd0);
    #1 chkb("st200_valid", Valid_OUT, 1'b1);
    step();
    load(32'h300);
    #1 chkb("ld300_wait", Valid_OUT, 1'b0);
    step();
    chkb("ld300_read", DC_Read, 1'b1);
    chkb("ld300_no_write", DC_Write, 1'b0);
    chk ("ld300_addr", DC_Addr, 32'h300);
    step(); step(); step();
    chkb("ld300_still_wait", Valid_OUT, 1'b0);
    DC_Valid = 1'b1; DC_RData = 32'h1234_5678;
    #1 chkb("ld300_valid", Valid_OUT, 1'b1);
    chk ("ld300_rdata", RData_OUT, 32'h1234_5678);
    step();
    DC_Valid = 1'b0; idle();
    wait_write("st200_drain_wait");
    chk("st200_drain_addr", DC_Addr, 32'h200);
    chk("st200_drain_data", DC_WData, 32'hDEAD_BEEF);
    pulse(32'h0);
    step();

    // Same-word aligned word store then load
    store(32'h400, 32'hCAFE_F00D, 2'd0);
    #1 chkb("st400_valid", Valid_OUT, 1'b1);
    step();
    load(32'h400);
    #1;
`ifdef MEM_STORE_FWD_EN
    chkb("fwd_valid", Valid_OUT, 1'b1);
    chk ("fwd_rdata", RData_OUT, 32'hCAFE_F00D);
    step();
    idle();
    chkb("fwd_no_read", DC_Read, 1'b0);
    chkb("fwd_drains", DC_Write, 1'b1);
    pulse(32'h0);
`else
    chkb("conf_wait", Valid_OUT, 1'b0);
    step();
    chkb("conf_write", DC_Write, 1'b1);
    chkb("conf_no_read", DC_Read, 1'b0);
    chk ("conf_waddr", DC_Addr, 32'h400);
    DC_Valid = 1'b1;
    #1 chkb("conf_wait_dv", Valid_OUT, 1'b0);
    step();
    DC_Valid = 1'b0;
    chkb("conf_idle_gap", DC_Read, 1'b0);
    step();
    chkb("conf_read", DC_Read, 1'b1);
    chk ("conf_raddr", DC_Addr, 32'h400);
    DC_Valid = 1'b1; DC_RData = 32'hCAFE_F00D;
    #1 chkb("conf_valid", Valid_OUT, 1'b1);
    chk ("conf_rdata", RData_OUT, 32'hCAFE_F00D);
    step();
    DC_Valid = 1'b0; idle();
`endif
    step();

    // Byte store conflict always drains
    store(32'h401, 32'h0000_00AB, 2'd1);
    #1 chkb("st401_valid", Valid_OUT, 1'b1);
    step();
    load(32'h400);
    #1 chkb("byte_conf_wait", Valid_OUT, 1'b0);
    step();
    chkb("byte_write", DC_Write, 1'b1);
    chkb("byte_no_read", DC_Read, 1'b0);
    chk ("byte_addr", DC_Addr, 32'h401);
    chk ("byte_size", 32'(DC_WSize), 32'd1);
    DC_Valid = 1'b1;
    #1 chkb("byte_wait_dv", Valid_OUT, 1'b0);
    step();
    DC_Valid = 1'b0;
    step();
    chkb("byte_read", DC_Read, 1'b1);
    DC_Valid = 1'b1; DC_RData = 32'h0000_00AB;
    #1 chkb("byte_valid", Valid_OUT, 1'b1);
    chk ("byte_rdata", RData_OUT, 32'h0000_00AB);
    step();
    DC_Valid = 1'b0; idle();
    step();

    // Flush behind three queued stores
    for (int i = 0; i < 3; i++) begin
      store(32'h500 + 32'(4*i), 32'hB000_0000 + 32'(i), 2'd0);
      #1 chkb("fl_st_valid", Valid_OUT, 1'b1);
      step();
    end
    idle(); MemFlush_IN = 1'b1;
    nw = 0; done = 1'b0;
    for (int unsigned c = 0; c < 100 && !done; c++) begin
      if (DC_Flush) begin
        chk("flush_after_writes", 32'(nw), 32'd3);
        DC_Valid = 1'b1;
        #1 chkb("flush_valid", Valid_OUT, 1'b1);
        step();
        DC_Valid = 1'b0; idle();
        done = 1'b1;
      end else if (DC_Write) begin
        chk("flush_wr_addr", DC_Addr, 32'h500 + 32'(4*nw));
        nw++;
        DC_Valid = 1'b1;
        #1 chkb("flush_not_done", Valid_OUT, 1'b0);
        step();
        DC_Valid = 1'b0;
      end else begin
        step();
      end
    end
    chkb("flush_done", done, 1'b1);
    chkb("flush_cleared", DC_Flush, 1'b0);
    step();

    // Reset while a drain waits on DC_Valid
    store(32'h600, 32'h0000_0066, 2'd0);
    #1;
    step();
    idle();
    step();
    chkb("rmid_write_up", DC_Write, 1'b1);
    #2 RESET = 1'b0;
    #1 chkb("rmid_write_drop", DC_Write, 1'b0);
    chk ("rmid_addr_clr", DC_Addr, 32'h0);
    step();
    RESET = 1'b1;
    load(32'h600);
    #1;
    step();
    chkb("rmid_load_read", DC_Read, 1'b1);
    chkb("rmid_no_write", DC_Write, 1'b0);
    DC_Valid = 1'b1; DC_RData = 32'h0000_0077;
    #1 chkb("rmid_load_valid", Valid_OUT, 1'b1);
    chk ("rmid_load_rdata", RData_OUT, 32'h0000_0077);
    step();
    DC_Valid = 1'b0; idle();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
